mod14_count_monitor: RTL and testbench
======================================

# mod14_count_monitor

Downstream consumer of the mod-14 counter's `count` bus.

- **Checking:** checks that the sequence steps legally (0..13, wrapping 13→0) and flags any illegal value or skipped step.
- **Wrap counting:** emits a pulse on each wrap and accumulates a count of completed cycles.
- **Display:** converts the current count to two BCD digits and drives a time-multiplexed two-digit 7-segment display.

It sits between the counter and the board I/O, and serves as both run-time checker and display driver.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clock cycles each digit stays selected; legal values are 2 or more.
- `WRAP_W`, default 8: width of the wrap counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `count`  in  4  count value from the mod-14 counter.
- `count_vld`  in  1  high while the upstream counter is running. Low means: ignore `count` and stop sequence tracking.
- `wrap_pulse`  out  1  one-cycle pulse for each legal 13→0 step.
- `wraps`  out  WRAP_W  number of completed cycles, modulo 2^WRAP_W.
- `tens`  out  4  BCD tens digit of the last legal sample.
- `ones`  out  4  BCD ones digit of the last legal sample.
- `dig_sel`  out  2  one-hot digit enable: 01 = ones, 10 = tens.
- `seg`  out  7  active-high segments in `{g,f,e,d,c,b,a}` order.
- `seq_err`  out  1  sticky error flag.

## Operation
- **Internal state:** `prev` (4 bits) and `prev_vld`. Each edge with `count_vld`=1 loads `prev`←`count` and sets `prev_vld`←1. Each edge with `count_vld`=0 clears `prev_vld`; all other state holds.
- **Sequence check:** performed only when `count_vld`=1 and `prev_vld`=1.
  - Expected value = 0 if `prev`==13, else `prev`+1.
  - Mismatch sets `seq_err`.
  - If `prev` is illegal, every step mismatches.
- **First sample rule:** the first sample after `count_vld` rises is not sequence-checked. It is still range-checked.
- **Range check:** `count`≥14 with `count_vld`=1 sets `seq_err`, whether or not `prev_vld` is set.
- **seq_err clearing:** only `rst` clears `seq_err`.
- **Wrap detection:** fires when `prev_vld`=1, `prev`==13 and `count`==0.
  - `wrap_pulse`←1 for one cycle.
  - `wraps`←`wraps`+1, wrapping modulo 2^WRAP_W.
  - A step such as 13→5 is an error, not a wrap.
- **BCD conversion:** on a legal sample (`count_vld`=1 and `count`≤13):
  - `tens`←(`count`≥10).
  - `ones`←`count`−10·`tens`.
  - On an illegal or invalid sample, `tens`/`ones` hold.
- **Scan divider:** `div` runs 0..SCAN_DIV−1 and wraps to 0. When `div`==SCAN_DIV−1, `dig_sel` toggles between 01 and 10 on the same edge.
- **Segment decode:** combinational from the registered `dig_sel`, `tens` and `ones`. Digit patterns 0..9 are 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Leading-zero blanking: when `dig_sel`=10 and `tens`=0, `seg`=00.
- **Reset values:** `wraps`=0, `wrap_pulse`=0, `seq_err`=0, `tens`=0, `ones`=0, `prev`=0, `prev_vld`=0, `div`=0, `dig_sel`=01, `seg`=3F.
- **Reset mid-operation:** `rst` overrides everything, including a simultaneous wrap or error. The first valid sample after reset is not sequence-checked.

## Timing
- **Latency:** `count` is sampled at edge N. `wrap_pulse`, `wraps`, `seq_err`, `tens` and `ones` all reflect that sample after edge N; latency is 1 cycle.
- **wrap_pulse:** high for exactly one cycle per wrap. Back-to-back wraps are impossible under a legal sequence.
- **Wrap counter overflow:** a wrap when `wraps`=2^WRAP_W−1 gives `wraps`=0. No overflow flag is produced.
- **seg timing:** `seg` changes in the same cycle as `dig_sel` or the BCD registers; it adds no extra latency.
- **Scan period:** each digit is held for exactly SCAN_DIV cycles, so the full refresh period is 2·SCAN_DIV cycles. The scan runs independently of `count_vld`.
- **Simultaneous events:**
  - Wrap plus `count_vld` dropping in the same cycle is impossible, because wrap requires `count_vld`=1.
  - An error and a BCD hold can occur in the same cycle; they are independent.

## Test plan
1. **Reset:** hold `rst`=1 for 3 cycles with `count` toggling.
   - Expect `wraps`=0, `seq_err`=0, `tens`=`ones`=0, `dig_sel`=01, `seg`=3F, `wrap_pulse`=0.
2. **Free run:** after reset, drive 30 legal counts 0,1,…,13,0,…,13,0,1 with `count_vld`=1.
   - `wrap_pulse` fires one cycle after each 0 that follows 13 (twice); final `wraps`=2.
   - `seq_err`=0 throughout.
   - One cycle after `count`=12 is sampled: `tens`=1, `ones`=2.
3. **Skip:** drive 5 then 7.
   - `seq_err`=1 one cycle after 7 is sampled.
   - `seq_err` remains 1 through 20 further legal counts and clears only on `rst`.
4. **Illegal value:** drive 3, then 14.
   - `seq_err`=1; `tens`/`ones` hold 0/3.
   - A following `count`=0 causes no wrap.
5. **Valid gap:** drive 4, then `count_vld`=0 for 3 cycles, then resume at 9, 10.
   - `seq_err`=0, and `tens`/`ones` end at 1/0.
6. **Display, with SCAN_DIV=4 and WRAP_W=2:**
   - With the last legal sample 12: `dig_sel` alternates 01/10 every 4 cycles, and `seg` alternates 5B/06.
   - With the last legal sample 7: `seg` shows 07 on the ones digit and 00 on the tens digit.
   - After 4 wraps, `wraps`=0.

Source files
------------

// File: rtl/mod14_count_monitor.sv
// Run-time checker and display driver for the mod-14 counter's count bus.
// Flags illegal values / skipped steps, counts wraps, and scans a 2-digit 7-segment display.
module mod14_count_monitor #(
  parameter int SCAN_DIV = 4,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count,
  input  logic              count_vld,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wraps,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic [1:0]        dig_sel,
  output logic [6:0]        seg,
  output logic              seq_err
);

  localparam int              DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      LAST     = 4'd13;

  typedef enum logic [1:0] {
    DIG_ONES = 2'b01,
    DIG_TENS = 2'b10
  } dig_t;

  dig_t             dig_q, dig_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [3:0] prev;
  logic       prev_vld;
  logic       legal;
  logic       step_ok;
  logic       do_check;
  logic       is_wrap;
  logic [3:0] exp_next;

  // An illegal prev can never be followed legally, even though prev+1 may alias to 0.
  always_comb begin
    legal    = (count <= LAST);
    exp_next = (prev == LAST) ? '0 : prev + 4'd1;
    step_ok  = (prev <= LAST) && (count == exp_next);
    do_check = count_vld && prev_vld;
    is_wrap  = do_check && (prev == LAST) && (count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_vld   <= 1'b0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      wraps      <= '0;
      tens       <= '0;
      ones       <= '0;
    end else begin
      wrap_pulse <= is_wrap;
      if (is_wrap)
        wraps <= wraps + WRAP_W'(1);
      if (count_vld) begin
        prev     <= count;
        prev_vld <= 1'b1;
        if (!legal || (prev_vld && !step_ok))
          seq_err <= 1'b1;
        if (legal) begin
          if (count >= 4'd10) begin
            tens <= 4'd1;
            ones <= count - 4'd10;
          end else begin
            tens <= 4'd0;
            ones <= count;
          end
        end
      end else begin
        prev_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      dig_q <= DIG_ONES;
    end else begin
      div_q <= div_d;
      dig_q <= dig_d;
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    dig_d = dig_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      dig_d = (dig_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [3:0] digit;

  always_comb begin
    digit = (dig_q == DIG_TENS) ? tens : ones;
    seg   = seg7(digit);
    if ((dig_q == DIG_TENS) && (tens == '0))
      seg = '0;
  end

  assign dig_sel = dig_q;

endmodule

// File: tb/tb_mod14_count_monitor.sv
// Scoreboard bench for mod14_count_monitor: stimulus pushes expected results,
// a monitor pops and compares them half a cycle after each sampled edge.
module tb_mod14_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       count_vld;
  logic       wrap_pulse;
  logic [1:0] wraps;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] dig_sel;
  logic [6:0] seg;
  logic       seq_err;

  mod14_count_monitor #(.SCAN_DIV(4), .WRAP_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .count_vld (count_vld),
    .wrap_pulse(wrap_pulse),
    .wraps     (wraps),
    .tens      (tens),
    .ones      (ones),
    .dig_sel   (dig_sel),
    .seg       (seg),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wp;
    logic [1:0] wraps;
    logic       err;
    logic [3:0] t;
    logic [3:0] o;
    logic [1:0] ds;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  logic stim_vld = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   n_since_rst = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string nm, input int v, input int got, input int want);
    if (got != want) begin
      $display("FAIL %s vec %0d: got %0h want %0h", nm, v, got, want);
      nerr++;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] c,
                       input logic e_wp, input logic [1:0] e_wraps, input logic e_err,
                       input logic [3:0] e_t, input logic [3:0] e_o);
    exp_t e;
    rst       = r;
    count_vld = v;
    count     = c;
    stim_vld  = 1'b1;
    if (r) n_since_rst = 0;
    else   n_since_rst++;
    e.wp    = e_wp;
    e.wraps = e_wraps;
    e.err   = e_err;
    e.t     = e_t;
    e.o     = e_o;
    e.ds    = ((n_since_rst % 8) >= 4) ? 2'b10 : 2'b01;
    if (e.ds == 2'b10) e.seg = (e_t == 4'd0) ? 7'h00 : seg_tab[e_t];
    else               e.seg = seg_tab[e_o];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge that sampled a vector yields one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (stim_vld) begin
        @(negedge clk);
        if (q.size() == 0) begin
          $display("FAIL scoreboard_underflow vec %0d: got 0 entries want 1", nvec);
          nerr++;
        end else begin
          e = q.pop_front();
          check("wrap_pulse", nvec, int'(wrap_pulse), int'(e.wp));
          check("wraps",      nvec, int'(wraps),      int'(e.wraps));
          check("seq_err",    nvec, int'(seq_err),    int'(e.err));
          check("tens",       nvec, int'(tens),       int'(e.t));
          check("ones",       nvec, int'(ones),       int'(e.o));
          check("dig_sel",    nvec, int'(dig_sel),    int'(e.ds));
          check("seg",        nvec, int'(seg),        int'(e.seg));
          nvec++;
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; count = '0; count_vld = 1'b0;

    // reset held 3 cycles with count toggling
    drive(1, 1, 4'd14, 0, 0, 0, 0, 0);
    drive(1, 1, 4'd13, 0, 0, 0, 0, 0);
    drive(1, 0, 4'd5,  0, 0, 0, 0, 0);

    // free run: 30 legal counts, two wraps
    for (int i = 0; i < 30; i++) begin
      c = i % 14;
      drive(0, 1, 4'(c), (i == 14) || (i == 28),
            2'((i >= 28) ? 2 : ((i >= 14) ? 1 : 0)), 0, 4'(c / 10), 4'(c % 10));
    end

    // skip 5 -> 7, sticky through 20 legal counts
    drive(1, 0, 4'd0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'd5, 0, 0, 0, 0, 5);
    drive(0, 1, 4'd7, 0, 0, 1, 0, 7);
    for (int i = 0; i < 20; i++) begin
      c = (8 + i) % 14;
      drive(0, 1, 4'(c), i == 6, 2'((i >= 6) ? 1 : 0), 1, 4'(c / 10), 4'(c % 10));
    end
    drive(1, 0, 4'd0, 0, 0, 0, 0, 0);

    // illegal value, no wrap out of it; 13 -> 5 is not a wrap
    drive(0, 1, 4'd3,  0, 0, 0, 0, 3);
    drive(0, 1, 4'd14, 0, 0, 1, 0, 3);
    drive(0, 1, 4'd0,  0, 0, 1, 0, 0);
    drive(0, 1, 4'd13, 0, 0, 1, 1, 3);
    drive(0, 1, 4'd5,  0, 0, 1, 0, 5);

    // valid gap
    drive(1, 0, 4'd0,  0, 0, 0, 0, 0);
    drive(0, 1, 4'd4,  0, 0, 0, 0, 4);
    drive(0, 0, 4'd14, 0, 0, 0, 0, 4);
    drive(0, 0, 4'd2,  0, 0, 0, 0, 4);
    drive(0, 0, 4'd15, 0, 0, 0, 0, 4);
    drive(0, 1, 4'd9,  0, 0, 0, 0, 9);
    drive(0, 1, 4'd10, 0, 0, 0, 1, 0);
    drive(0, 1, 4'd11, 0, 0, 0, 1, 1);
    drive(0, 1, 4'd12, 0, 0, 0, 1, 2);
    drive(0, 1, 4'd13, 0, 0, 0, 1, 3);
    drive(0, 0, 4'd0,  0, 0, 0, 1, 3);
    drive(0, 1, 4'd0,  0, 0, 0, 0, 0);
    drive(0, 1, 4'd1,  0, 0, 0, 0, 1);

    // display: 12 then 7, scanned over full periods
    drive(1, 0, 4'd0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'd12, 0, 0, 0, 1, 2);
    for (int i = 0; i < 16; i++) drive(0, 0, 4'd3, 0, 0, 0, 1, 2);
    drive(0, 1, 4'd7, 0, 0, 0, 0, 7);
    for (int i = 0; i < 8; i++) drive(0, 0, 4'd9, 0, 0, 0, 0, 7);

    // four wraps overflow a 2-bit counter
    drive(0, 1, 4'd13, 0, 0, 0, 1, 3);
    for (int w = 1; w <= 4; w++) begin
      drive(0, 1, 4'd0, 1, 2'(w % 4), 0, 0, 0);
      if (w < 4)
        for (int k = 1; k <= 13; k++)
          drive(0, 1, 4'(k), 0, 2'(w), 0, 4'(k / 10), 4'(k % 10));
    end

    // reset overrides a simultaneous wrap; first sample after reset unchecked
    for (int k = 1; k <= 13; k++) drive(0, 1, 4'(k), 0, 0, 0, 4'(k / 10), 4'(k % 10));
    drive(0, 1, 4'd0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 13; k++) drive(0, 1, 4'(k), 0, 1, 0, 4'(k / 10), 4'(k % 10));
    drive(1, 1, 4'd0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'd5, 0, 0, 0, 0, 5);
    drive(0, 1, 4'd6, 0, 0, 0, 0, 6);

    stim_vld = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
      nerr++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
